// File: rtl/serial_rx4.sv
// serial_rx4: LSB-first serial word receiver with a ready/valid output stage.
// Bits arrive on rx_in when rx_en is high; fn_in marks the frame end. A
// completed word moves to an independent holding register (data_out) so the
// next frame can be shifted while the consumer still holds the old word.
// Optional feature macro: RX_PARITY_EN (adds one even-parity bit per frame).
module serial_rx4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  input  logic             rx_en,
  input  logic             fn_in,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [2:0]       bit_count,
  output logic             overrun,
  output logic             frame_err
);

`ifdef RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  // Counter is one bit wider than the port so WIDTH=8 can hold the value 8.
  localparam logic [3:0] FULL = 4'(WIDTH);
  localparam logic [3:0] LAST = 4'(WIDTH - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] shift_q;
  logic             deliver;

  assign bit_count = cnt[2:0];

  // A word is handed to the output stage on the edge where the frame completes.
  always_comb begin
    deliver = 1'b0;
`ifdef RX_PARITY_EN
    deliver = (state == CHECK) && rx_en && !fn_in && !(^shift_q ^ rx_in);
`else
    deliver = (state == SHIFT) && (cnt == FULL);
`endif
  end

  // Frame FSM: capture bits, detect aborted frames and (optionally) parity errors.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_q   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // fn_in wins over rx_en, so a coincident bit is dropped.
          if (rx_en && !fn_in) begin
            shift_q[0] <= rx_in;
            cnt        <= 4'd1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == FULL) begin
            // Word already taken by the output stage this edge.
            cnt   <= '0;
            state <= IDLE;
          end else if (fn_in) begin
            cnt       <= '0;
            shift_q   <= '0;
            state     <= IDLE;
            frame_err <= 1'b1;
          end else if (rx_en) begin
            for (int i = 0; i < WIDTH; i++)
              if (cnt == 4'(i)) shift_q[i] <= rx_in;
            cnt <= cnt + 4'd1;
`ifdef RX_PARITY_EN
            if (cnt == LAST) state <= CHECK;
`endif
          end
        end
`ifdef RX_PARITY_EN
        CHECK: begin
          if (fn_in) begin
            cnt       <= '0;
            shift_q   <= '0;
            state     <= IDLE;
            frame_err <= 1'b1;
          end else if (rx_en) begin
            cnt   <= '0;
            state <= IDLE;
            if (!deliver) frame_err <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: load on delivery unless the old word is still unconsumed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (deliver) begin
      if (data_valid && !data_ready) begin
        overrun <= 1'b1;
      end else begin
        data_out   <= shift_q;
        data_valid <= 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_rx4.sv
// Directed bench for serial_rx4 (WIDTH=4). Expected words go into a
// scoreboard queue; a negedge monitor pops and compares on each handshake.
module tb_serial_rx4;
  logic       clk = 1'b0;
  logic       reset, rx_in, rx_en, fn_in, data_ready;
  logic [3:0] data_out;
  logic       data_valid, overrun, frame_err;
  logic [2:0] bit_count;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  serial_rx4 #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .rx_en(rx_en), .fn_in(fn_in),
    .data_ready(data_ready), .data_out(data_out), .data_valid(data_valid),
    .bit_count(bit_count), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && data_valid && data_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %h expected none", data_out);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL word: got %h expected %h", data_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_en = 1'b1;
    rx_in = b;
    tick();
    rx_en = 1'b0;
    rx_in = ~b;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) send_bit(w[i]);
  endtask

  initial begin
    reset = 1'b0; rx_in = 1'b0; rx_en = 1'b0; fn_in = 1'b0; data_ready = 1'b0;
    tick(); tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    reset = 1'b1;
    tick();

`ifdef RX_PARITY_EN
    data_ready = 1'b1;
    exp_q.push_back(4'h7);
    send_word(4'h7);
    chk("par_cnt_check", bit_count, 4);
    send_bit(1'b1);
    chk("par_ok_valid", data_valid, 1);
    chk("par_ok_err", frame_err, 0);
    tick();
    send_word(4'h7);
    send_bit(1'b0);
    chk("par_bad_err", frame_err, 1);
    chk("par_bad_valid", data_valid, 0);
    tick();
    chk("par_bad_err_pulse", frame_err, 0);
`else
    // 1,0,1,1 -> 4'hD, bit_count 1,2,3,4,0
    data_ready = 1'b1;
    exp_q.push_back(4'hD);
    send_bit(1'b1); chk("cnt1", bit_count, 1);
    send_bit(1'b0); chk("cnt2", bit_count, 2);
    send_bit(1'b1); chk("cnt3", bit_count, 3);
    send_bit(1'b1); chk("cnt4", bit_count, 4);
    chk("valid_latency", data_valid, 0);
    tick();
    chk("cnt0", bit_count, 0);
    chk("valid_d", data_valid, 1);
    tick();
    chk("valid_one_cycle", data_valid, 0);

    // rx_en gaps 1,0,0,1,1,0,1 with bits 0,1,1,1 -> 4'hE
    exp_q.push_back(4'hE);
    send_bit(1'b0); tick(); tick();
    send_bit(1'b1); send_bit(1'b1); tick();
    send_bit(1'b1);
    chk("gap_cnt", bit_count, 4);
    tick(); tick();

    // Overrun: A held with ready low, 5 lost.
    data_ready = 1'b0;
    exp_q.push_back(4'hA);
    send_word(4'hA); tick();
    send_word(4'h5); tick();
    chk("ovr_flag", overrun, 1);
    chk("ovr_keep", data_out, 4'hA);
    chk("ovr_valid", data_valid, 1);
    data_ready = 1'b1;
    tick();
    chk("ovr_sticky", overrun, 1);
    chk("ovr_consumed", data_valid, 0);

    // Abort after two bits, then a clean 4'h3.
    send_bit(1'b1); send_bit(1'b0);
    fn_in = 1'b1; tick(); fn_in = 1'b0;
    chk("abort_err", frame_err, 1);
    chk("abort_cnt", bit_count, 0);
    tick();
    chk("abort_pulse", frame_err, 0);
    exp_q.push_back(4'h3);
    send_word(4'h3); tick(); tick();

    // fn_in with rx_en mid-frame: bit dropped, frame aborted.
    send_bit(1'b1);
    fn_in = 1'b1; rx_en = 1'b1; rx_in = 1'b1;
    tick();
    fn_in = 1'b0; rx_en = 1'b0;
    chk("fn_prio_cnt", bit_count, 0);
    chk("fn_prio_err", frame_err, 1);
    // fn_in in IDLE does nothing.
    fn_in = 1'b1; tick(); fn_in = 1'b0;
    chk("fn_idle_err", frame_err, 0);

    // New word completes on the edge the old one is consumed.
    data_ready = 1'b0;
    exp_q.push_back(4'h9);
    exp_q.push_back(4'h6);
    send_word(4'h9); tick();
    send_word(4'h6);
    data_ready = 1'b1;
    tick();
    chk("b2b_valid", data_valid, 1);
    chk("b2b_data", data_out, 4'h6);
    chk("b2b_no_ovr", overrun, 1);  // still sticky from the earlier overrun
    tick();

    // Reset mid-frame with a word held: everything clears, no frame_err.
    data_ready = 1'b0;
    send_word(4'h3); tick();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("pre_rst_cnt", bit_count, 3);
    chk("pre_rst_valid", data_valid, 1);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_valid", data_valid, 0);
    chk("mid_rst_cnt", bit_count, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_err", frame_err, 0);
    tick();
    chk("post_rst_err", frame_err, 0);

    // Overrun-free back-to-back after reset.
    data_ready = 1'b0;
    exp_q.push_back(4'hC);
    exp_q.push_back(4'h1);
    send_word(4'hC); tick();
    send_word(4'h1);
    data_ready = 1'b1;
    tick();
    chk("b2b2_no_ovr", overrun, 0);
    tick();
`endif

    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
